// File: rtl/channel_event_scheduler_pkg.sv
// Shared constants and types for the channel event scheduler.
// Channel code convention: code = channel index + 1, code 0 = no channel.
// Optional build macro: SCHED_TIMESTAMP_EN (adds the per-channel timestamp width).
package channel_event_scheduler_pkg;

  localparam int unsigned SCHED_N_CH   = 7;
  localparam int unsigned SCHED_CH_W   = 3;
  localparam int unsigned SCHED_DROP_W = 8;
`ifdef SCHED_TIMESTAMP_EN
  localparam int unsigned SCHED_TS_W   = 8;
`endif

  localparam logic [SCHED_CH_W-1:0] CH_NONE = '0;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/channel_event_scheduler_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit strictly
// after ptr, wrapping modulo N_CH. any is low when no request is set.
module rr_pick #(
  parameter int unsigned N_CH  = 7,
  parameter int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int unsigned      w_pos;
  logic [IDX_W-1:0] w_pidx;
  logic             w_found;

  // Scan N_CH positions starting one past ptr; first hit wins.
  always_comb begin
    any     = |req;
    idx     = '0;
    w_pos   = 0;
    w_pidx  = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      w_pos = 32'(ptr) + k;
      if (w_pos >= N_CH) w_pos = w_pos - N_CH;
      w_pidx = IDX_W'(w_pos);
      if (!w_found && req[w_pidx]) begin
        w_found = 1'b1;
        idx     = w_pidx;
      end
    end
  end

endmodule

// File: rtl/channel_event_scheduler.sv
// Channel event scheduler: latches per-channel event pulses as sticky pending
// flags and serializes them, round-robin, onto a valid/ready stream of
// 1-based channel codes. Counts pulses lost to an already-pending channel.
// Optional build macro: SCHED_TIMESTAMP_EN (free-running counter, per-channel
// capture registers and the evt_ts output port).
module channel_event_scheduler
  import channel_event_scheduler_pkg::*;
#(
  parameter int unsigned N_CH   = SCHED_N_CH,
  parameter int unsigned CH_W   = SCHED_CH_W,
  parameter int unsigned DROP_W = SCHED_DROP_W
`ifdef SCHED_TIMESTAMP_EN
  ,
  parameter int unsigned TS_W   = SCHED_TS_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_channel,
  output logic [N_CH-1:0]   pending,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_flag
`ifdef SCHED_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   evt_ts
`endif
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = $clog2(N_CH + 1);

  sched_state_t      r_state;
  logic              r_evt_valid;
  logic [CH_W-1:0]   r_evt_channel;
  logic [IDX_W-1:0]  r_sel_idx;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [N_CH-1:0]   r_pending;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_drop_flag;

  logic [N_CH-1:0]   w_pulse;
  logic [N_CH-1:0]   w_clr;
  logic [N_CH-1:0]   w_pend_next;
  logic [N_CH-1:0]   w_drop;
  logic [CNT_W-1:0]  w_drop_n;
  logic [DROP_W:0]   w_drop_sum;
  logic              w_any;
  logic [IDX_W-1:0]  w_pick;

  // Per-channel clear/arm/drop terms and the number of channels dropping now.
  always_comb begin
    w_drop_n = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_pulse[i] = enable && ch_pulse[i];
      w_clr[i]   = r_evt_valid && evt_ready && (r_evt_channel == CH_W'(i + 1));
      w_drop[i]  = w_pulse[i] && r_pending[i] && !w_clr[i];
      w_pend_next[i] = (r_pending[i] && !w_clr[i]) || w_pulse[i];
      w_drop_n   = w_drop_n + CNT_W'(w_drop[i]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W + 1)'(w_drop_n);
  end

  rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (r_pending),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  // Pending flags and the saturating drop counter / sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_drop_cnt  <= '0;
      r_drop_flag <= 1'b0;
    end else begin
      r_pending  <= w_pend_next;
      r_drop_cnt <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      if (|w_drop) r_drop_flag <= 1'b1;
    end
  end

`ifdef SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_ts [N_CH];
  logic [TS_W-1:0] r_evt_ts;

  // Free-running timestamp; a channel captures it when newly armed or re-armed
  // on its accept cycle. Dropped pulses leave the capture untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts_cnt <= '0;
      for (int unsigned i = 0; i < N_CH; i++) r_ts[i] <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (w_pulse[i] && (!r_pending[i] || w_clr[i])) r_ts[i] <= r_ts_cnt;
      end
    end
  end
`endif

  // Two-state presentation FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_evt_valid   <= 1'b0;
      r_evt_channel <= CH_NONE;
      r_sel_idx     <= '0;
      r_rr_ptr      <= IDX_W'(N_CH - 1);
`ifdef SCHED_TIMESTAMP_EN
      r_evt_ts      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_evt_valid   <= 1'b1;
            r_evt_channel <= CH_W'(w_pick) + CH_W'(1);
            r_sel_idx     <= w_pick;
`ifdef SCHED_TIMESTAMP_EN
            r_evt_ts      <= r_ts[w_pick];
`endif
            r_state       <= PRESENT;
          end else begin
            r_evt_valid   <= 1'b0;
            r_evt_channel <= CH_NONE;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            r_rr_ptr      <= r_sel_idx;
            r_evt_valid   <= 1'b0;
            r_evt_channel <= CH_NONE;
`ifdef SCHED_TIMESTAMP_EN
            r_evt_ts      <= '0;
`endif
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign evt_valid   = r_evt_valid;
  assign evt_channel = r_evt_channel;
  assign pending     = r_pending;
  assign drop_cnt    = r_drop_cnt;
  assign drop_flag   = r_drop_flag;
`ifdef SCHED_TIMESTAMP_EN
  assign evt_ts      = r_evt_ts;
`endif

endmodule

// File: tb/tb_channel_event_scheduler.sv
// Directed self-checking bench for channel_event_scheduler.
// Build with SCHED_TIMESTAMP_EN defined to also exercise the evt_ts port.
module tb_channel_event_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [6:0] ch_pulse = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_channel;
  logic [6:0] pending;
  logic [7:0] drop_cnt;
  logic       drop_flag;
`ifdef SCHED_TIMESTAMP_EN
  logic [7:0] evt_ts;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  channel_event_scheduler #(
    .N_CH   (7),
    .CH_W   (3),
    .DROP_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ch_pulse    (ch_pulse),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_channel (evt_channel),
    .pending     (pending),
    .drop_cnt    (drop_cnt),
    .drop_flag   (drop_flag)
`ifdef SCHED_TIMESTAMP_EN
    ,
    .evt_ts      (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle; inputs driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_pulse = '0; evt_ready = 1'b0; enable = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pending !== 7'h00) begin n_fail++; $display("FAIL reset_pending: got %h exp 00", pending); end
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", evt_valid); end
    n_chk++; if (evt_channel !== 3'd0) begin n_fail++; $display("FAIL reset_channel: got %0d exp 0", evt_channel); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d exp 0", drop_cnt); end
    n_chk++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL reset_drop_flag: got %b exp 0", drop_flag); end
  endtask

  task automatic test_single_event();
    do_reset();
    evt_ready = 1'b1; ch_pulse = 7'b0000100;
    tick(); ch_pulse = '0;
    n_chk++; if (pending !== 7'b0000100) begin n_fail++; $display("FAIL single_pending_t1: got %b exp 0000100", pending); end
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t1: got %b exp 0", evt_valid); end
    tick();
    n_chk++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_t2: got %b exp 1", evt_valid); end
    n_chk++; if (evt_channel !== 3'd3) begin n_fail++; $display("FAIL single_channel_t2: got %0d exp 3", evt_channel); end
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t3: got %b exp 0", evt_valid); end
    n_chk++; if (evt_channel !== 3'd0) begin n_fail++; $display("FAIL single_channel_t3: got %0d exp 0", evt_channel); end
    n_chk++; if (pending !== 7'h00) begin n_fail++; $display("FAIL single_pending_t3: got %b exp 0000000", pending); end
  endtask

  task automatic test_round_robin();
    do_reset();
    evt_ready = 1'b1; ch_pulse = 7'h7F;
    tick(); ch_pulse = '0;
    n_chk++; if (pending !== 7'h7F) begin n_fail++; $display("FAIL rr_pending_full: got %b exp 1111111", pending); end
    for (int k = 0; k < 7; k++) begin
      tick();
      n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'(k + 1)) begin n_fail++; $display("FAIL rr_grant_%0d: got valid=%b ch=%0d exp valid=1 ch=%0d", k, evt_valid, evt_channel, k + 1); end
      tick();
      n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble_%0d: got valid=%b exp 0", k, evt_valid); end
    end
    n_chk++; if (pending !== 7'h00) begin n_fail++; $display("FAIL rr_drained: got %b exp 0000000", pending); end
    ch_pulse = 7'b1000001;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd1) begin n_fail++; $display("FAIL rr_wrap_first: got valid=%b ch=%0d exp valid=1 ch=1", evt_valid, evt_channel); end
    tick(); tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd7) begin n_fail++; $display("FAIL rr_wrap_second: got valid=%b ch=%0d exp valid=1 ch=7", evt_valid, evt_channel); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    evt_ready = 1'b0; ch_pulse = 7'b0000100;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd3) begin n_fail++; $display("FAIL bp_present: got valid=%b ch=%0d exp valid=1 ch=3", evt_valid, evt_channel); end
    for (int k = 0; k < 3; k++) begin
      ch_pulse = 7'b0000100;
      tick();
    end
    ch_pulse = '0;
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd3) begin n_fail++; $display("FAIL bp_held: got valid=%b ch=%0d exp valid=1 ch=3", evt_valid, evt_channel); end
    n_chk++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL bp_drop_cnt: got %0d exp 3", drop_cnt); end
    n_chk++; if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL bp_drop_flag: got %b exp 1", drop_flag); end
    evt_ready = 1'b1;
    tick();
    n_chk++; if (evt_valid !== 1'b0 || pending !== 7'h00) begin n_fail++; $display("FAIL bp_accept: got valid=%b pending=%b exp valid=0 pending=0000000", evt_valid, pending); end
    tick();
    n_chk++; if (evt_valid !== 1'b0 || drop_flag !== 1'b1) begin n_fail++; $display("FAIL bp_idle_after: got valid=%b flag=%b exp valid=0 flag=1", evt_valid, drop_flag); end
  endtask

  task automatic test_collision();
    do_reset();
    evt_ready = 1'b0; ch_pulse = 7'b0100000;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd6) begin n_fail++; $display("FAIL coll_present: got valid=%b ch=%0d exp valid=1 ch=6", evt_valid, evt_channel); end
    evt_ready = 1'b1; ch_pulse = 7'b0100000;
    tick(); ch_pulse = '0;
    n_chk++; if (evt_valid !== 1'b0 || pending !== 7'b0100000) begin n_fail++; $display("FAIL coll_rearm: got valid=%b pending=%b exp valid=0 pending=0100000", evt_valid, pending); end
    n_chk++; if (drop_cnt !== 8'd0 || drop_flag !== 1'b0) begin n_fail++; $display("FAIL coll_no_drop: got cnt=%0d flag=%b exp cnt=0 flag=0", drop_cnt, drop_flag); end
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd6) begin n_fail++; $display("FAIL coll_represent: got valid=%b ch=%0d exp valid=1 ch=6", evt_valid, evt_channel); end
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; ch_pulse = 7'h7F;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (pending !== 7'h00 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL enable_gate: got pending=%b valid=%b exp pending=0000000 valid=0", pending, evt_valid); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_present();
    do_reset();
    evt_ready = 1'b1; ch_pulse = 7'b0001000;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_channel !== 3'd4) begin n_fail++; $display("FAIL rmp_first: got ch=%0d exp 4", evt_channel); end
    tick();
    evt_ready = 1'b0; ch_pulse = 7'b0100001;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd6) begin n_fail++; $display("FAIL rmp_rr_pick: got valid=%b ch=%0d exp valid=1 ch=6", evt_valid, evt_channel); end
    ch_pulse = 7'b0100000;
    tick(); ch_pulse = '0;
    n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL rmp_drop_before: got %0d exp 1", drop_cnt); end
    rst = 1'b1;
    tick(); rst = 1'b0;
    n_chk++; if (evt_valid !== 1'b0 || evt_channel !== 3'd0) begin n_fail++; $display("FAIL rmp_outputs: got valid=%b ch=%0d exp valid=0 ch=0", evt_valid, evt_channel); end
    n_chk++; if (drop_cnt !== 8'd0 || drop_flag !== 1'b0 || pending !== 7'h00) begin n_fail++; $display("FAIL rmp_state: got cnt=%0d flag=%b pending=%b exp 0 0 0000000", drop_cnt, drop_flag, pending); end
    evt_ready = 1'b1; ch_pulse = 7'b0100001;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_channel !== 3'd1) begin n_fail++; $display("FAIL rmp_after_reset_first: got ch=%0d exp 1", evt_channel); end
    tick(); tick();
    n_chk++; if (evt_channel !== 3'd6) begin n_fail++; $display("FAIL rmp_after_reset_second: got ch=%0d exp 6", evt_channel); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    evt_ready = 1'b0; ch_pulse = 7'h7F;
    tick();
    tick();
    n_chk++; if (drop_cnt !== 8'd7) begin n_fail++; $display("FAIL sat_multi_drop: got %0d exp 7", drop_cnt); end
    tick(); ch_pulse = 7'b0000001;
    n_chk++; if (drop_cnt !== 8'd14 || pending !== 7'h7F) begin n_fail++; $display("FAIL sat_full_stall: got cnt=%0d pending=%b exp 14 1111111", drop_cnt, pending); end
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 9) begin
        n_chk++; if (drop_cnt !== 8'd24) begin n_fail++; $display("FAIL sat_midway: got %0d exp 24", drop_cnt); end
      end
    end
    ch_pulse = '0;
    n_chk++; if (drop_cnt !== 8'd255 || drop_flag !== 1'b1) begin n_fail++; $display("FAIL sat_limit: got cnt=%0d flag=%b exp 255 1", drop_cnt, drop_flag); end
    n_chk++; if (evt_valid !== 1'b1 || evt_channel !== 3'd1) begin n_fail++; $display("FAIL sat_held: got valid=%b ch=%0d exp 1 1", evt_valid, evt_channel); end
    do_reset();
  endtask

`ifdef SCHED_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    n_chk++; if (evt_ts !== 8'h00) begin n_fail++; $display("FAIL ts_reset: got %h exp 00", evt_ts); end
    for (int k = 0; k < 16; k++) tick();
    evt_ready = 1'b0; ch_pulse = 7'b0000010;
    tick(); ch_pulse = '0;
    tick();
    n_chk++; if (evt_channel !== 3'd2 || evt_ts !== 8'h10) begin n_fail++; $display("FAIL ts_capture: got ch=%0d ts=%h exp ch=2 ts=10", evt_channel, evt_ts); end
    ch_pulse = 7'b0000010;
    for (int k = 0; k < 5; k++) tick();
    ch_pulse = '0;
    n_chk++; if (evt_ts !== 8'h10) begin n_fail++; $display("FAIL ts_stall_hold: got %h exp 10", evt_ts); end
    evt_ready = 1'b1;
    tick();
    n_chk++; if (evt_valid !== 1'b0 || evt_ts !== 8'h00) begin n_fail++; $display("FAIL ts_idle_zero: got valid=%b ts=%h exp 0 00", evt_valid, evt_ts); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_enable();
    test_reset_mid_present();
    test_saturation();
`ifdef SCHED_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
